// File: rtl/count_word_packer.sv
`timescale 1ns/1ps
// count_word_packer
// Captures counter results on edge strobes, forms measurement words and
// writes them into the measurement FIFO through a small holding queue.
//
// Ports:
//   clk_12mhz     system clock
//   rst_n         asynchronous active-low reset
//   count_mode    0 = ADC mode (both phases), 1 = AVK differential mode
//   rising_edge   one-clk strobe, count_p is final
//   falling_edge  one-clk strobe, count_m is final
//   count_p       positive-phase count
//   count_m       negative-phase count
//   fifo_full     FIFO full flag
//   clr_overflow  one-clk clear of overflow and drop_cnt
//   fifo_wr_en    registered FIFO write strobe
//   count         registered FIFO write data, holds last written word
//   pending       holding queue occupancy
//   drop_cnt      saturating count of words lost to a full queue
//   overflow      sticky drop flag
//   wr_state      write FSM state (0 = IDLE, 1 = GAP), debug visibility
//
// FIFO write handshake: a word is transferred on every cycle in which
// fifo_wr_en is high; the FIFO has no ready beyond fifo_full, which is
// sampled in IDLE only, and the GAP cycle after each write lets the FIFO
// flags settle before the next decision.
module count_word_packer #(
    parameter int CNT_W  = 23,
    parameter int QDEPTH = 2,
    parameter int DROP_W = 8
) (
    input  logic                      clk_12mhz,
    input  logic                      rst_n,
    input  logic                      count_mode,
    input  logic                      rising_edge,
    input  logic                      falling_edge,
    input  logic [CNT_W-1:0]          count_p,
    input  logic [CNT_W-1:0]          count_m,
    input  logic                      fifo_full,
    input  logic                      clr_overflow,
    output logic                      fifo_wr_en,
    output logic [CNT_W:0]            count,
    output logic [$clog2(QDEPTH):0]   pending,
    output logic [DROP_W-1:0]         drop_cnt,
    output logic                      overflow,
    output logic                      wr_state
);

    localparam int AW = $clog2(QDEPTH);
    localparam int WW = CNT_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        GAP  = 1'b1
    } wr_state_t;

    wr_state_t state_q, state_d;

    logic [WW-1:0] mem [QDEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;

    logic [WW-1:0] word_rise, word_fall, word_diff;
    logic [WW-1:0] word0, word1;
    logic [1:0]    n_req, n_acc, n_drop;
    logic [AW:0]   free_slots;
    logic          pop;
    logic          wr_en_d;

    logic [DROP_W-1:0] drop_base, drop_next;
    logic [DROP_W:0]   drop_sum;

    assign word_rise = {1'b1, count_p};
    assign word_fall = {1'b0, count_m};
    // Wraps modulo 2^WW: a negative difference appears as two's complement.
    assign word_diff = {1'b0, count_p} - {1'b0, count_m};

    // Words requested this cycle, in enqueue order (rising word first).
    always_comb begin
        word0 = '0;
        word1 = '0;
        n_req = 2'd0;
        if (!count_mode) begin
            if (rising_edge && falling_edge) begin
                word0 = word_rise;
                word1 = word_fall;
                n_req = 2'd2;
            end else if (rising_edge) begin
                word0 = word_rise;
                n_req = 2'd1;
            end else if (falling_edge) begin
                word0 = word_fall;
                n_req = 2'd1;
            end
        end else if (falling_edge) begin
            word0 = word_diff;
            n_req = 2'd1;
        end
    end

    // Write FSM: next state and registered-output decisions.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        wr_en_d = 1'b0;
        case (state_q)
            IDLE: begin
                if ((pending != '0) && !fifo_full) begin
                    pop     = 1'b1;
                    wr_en_d = 1'b1;
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A pop in this cycle frees its slot before the pushes are admitted.
    assign free_slots = (AW+1)'(QDEPTH) - pending + (AW+1)'(pop);
    assign n_acc      = ((AW+1)'(n_req) <= free_slots) ? n_req : free_slots[1:0];
    assign n_drop     = n_req - n_acc;

    // A clear and a drop in the same cycle: the clear applies first, then
    // this cycle's drops are counted on top of zero.
    assign drop_base = clr_overflow ? '0 : drop_cnt;
    assign drop_sum  = {1'b0, drop_base} + (DROP_W+1)'(n_drop);
    assign drop_next = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];

    always_ff @(posedge clk_12mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fifo_wr_en <= 1'b0;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            pending    <= '0;
            drop_cnt   <= '0;
            overflow   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fifo_wr_en <= wr_en_d;
            if (pop) begin
                count <= mem[rd_ptr];
            end
            rd_ptr   <= rd_ptr + AW'(pop);
            wr_ptr   <= wr_ptr + AW'(n_acc);
            pending  <= pending + (AW+1)'(n_acc) - (AW+1)'(pop);
            drop_cnt <= drop_next;
            if (n_drop != 2'd0) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    // Queue storage needs no reset: occupancy and pointers define validity.
    always_ff @(posedge clk_12mhz) begin
        if (n_acc != 2'd0) begin
            mem[wr_ptr] <= word0;
        end
        if (n_acc == 2'd2) begin
            mem[wr_ptr + AW'(1)] <= word1;
        end
    end

    assign wr_state = state_q;

endmodule

// File: tb/tb_count_word_packer.sv
`timescale 1ns/1ps
module tb_count_word_packer;

  localparam int CNT_W  = 23;
  localparam int QDEPTH = 2;
  localparam int DROP_W = 8;
  localparam int WW     = CNT_W + 1;

  // ---------------- clock / reset ----------------
  logic clk_12mhz = 1'b0;
  logic rst_n = 1'b0;
  always #41 clk_12mhz = ~clk_12mhz;

  logic             count_mode = 1'b0;
  logic             rising_edge = 1'b0;
  logic             falling_edge = 1'b0;
  logic [CNT_W-1:0] count_p = '0;
  logic [CNT_W-1:0] count_m = '0;
  logic             fifo_full = 1'b0;
  logic             clr_overflow = 1'b0;
  logic             fifo_wr_en;
  logic [WW-1:0]    count;
  logic [1:0]       pending;
  logic [DROP_W-1:0] drop_cnt;
  logic             overflow;
  logic             wr_state;

  count_word_packer #(.CNT_W(CNT_W), .QDEPTH(QDEPTH), .DROP_W(DROP_W)) dut (
    .clk_12mhz    (clk_12mhz),
    .rst_n        (rst_n),
    .count_mode   (count_mode),
    .rising_edge  (rising_edge),
    .falling_edge (falling_edge),
    .count_p      (count_p),
    .count_m      (count_m),
    .fifo_full    (fifo_full),
    .clr_overflow (clr_overflow),
    .fifo_wr_en   (fifo_wr_en),
    .count        (count),
    .pending      (pending),
    .drop_cnt     (drop_cnt),
    .overflow     (overflow),
    .wr_state     (wr_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [WW-1:0] exp_q[$];
  logic prev_wr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk_12mhz) begin
    if (!rst_n) begin
      prev_wr = 1'b0;
    end else begin
      if (fifo_wr_en) begin
        chk("wr_back_to_back", {31'd0, prev_wr}, 32'd0);
        chk("wr_while_full", {31'd0, fifo_full}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=%0h expected=none", count);
        end else begin
          chk("wr_word", {8'd0, count}, {8'd0, exp_q.pop_front()});
        end
      end
      prev_wr = fifo_wr_en;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk_12mhz);
    #1;
  endtask

  task automatic strobe(input logic m, input logic r, input logic f,
                        input logic [CNT_W-1:0] cp, input logic [CNT_W-1:0] cm);
    tick();
    count_mode   = m;
    rising_edge  = r;
    falling_edge = f;
    count_p      = cp;
    count_m      = cm;
    tick();
    rising_edge  = 1'b0;
    falling_edge = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    tick();
    tick();
    tick();
    chk({name, "_drain"}, exp_q.size(), 32'd0);
    chk({name, "_pending"}, {30'd0, pending}, 32'd0);
  endtask

  task automatic clear_flags();
    tick();
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic             mode;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] cp;
    logic [CNT_W-1:0] cm;
    logic             exp_wr;
    logic [WW-1:0]    exp_word;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b0, 23'h012345, 23'h000000, 1'b1, 24'h812345};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 23'h000000, 23'h000010, 1'b1, 24'h000010};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 23'd100,    23'd40,     1'b1, 24'd60};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 23'd40,     23'd100,    1'b1, 24'hFFFFC4};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 23'h000123, 23'h000001, 1'b0, 24'h000000};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 23'h7FFFFF, 23'h000000, 1'b1, 24'hFFFFFF};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 23'h7FFFFF, 23'h7FFFFF, 1'b1, 24'h7FFFFF};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 23'h000000, 23'h7FFFFF, 1'b1, 24'h800001};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 23'd5,      23'd7,      1'b1, 24'hFFFFFE};

    // reset state
    tick();
    tick();
    chk("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    chk("rst_count", {8'd0, count}, 32'd0);
    chk("rst_pending", {30'd0, pending}, 32'd0);
    chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    tick();

    // first-write latency: enqueue at edge k, write pulse after edge k+1
    exp_q.push_back(24'h812345);
    strobe(1'b0, 1'b1, 1'b0, 23'h012345, 23'h0);
    chk("lat_pending_k", {30'd0, pending}, 32'd1);
    chk("lat_wr_k", {31'd0, fifo_wr_en}, 32'd0);
    tick();
    chk("lat_wr_k1", {31'd0, fifo_wr_en}, 32'd1);
    chk("lat_count_k1", {8'd0, count}, 32'h812345);
    tick();
    chk("lat_gap", {31'd0, fifo_wr_en}, 32'd0);
    chk("hold_count", {8'd0, count}, 32'h812345);
    drain("latency");

    // table-driven word forming
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].exp_wr) exp_q.push_back(vecs[i].exp_word);
      strobe(vecs[i].mode, vecs[i].rise, vecs[i].fall, vecs[i].cp, vecs[i].cm);
      chk($sformatf("vec%0d_pending", i), {30'd0, pending}, {31'd0, vecs[i].exp_wr});
      drain($sformatf("vec%0d", i));
    end

    // backpressure: 3 strobes into a full FIFO, then release in mode 1
    tick();
    fifo_full = 1'b1;
    exp_q.push_back(24'h800001);
    exp_q.push_back(24'h800002);
    strobe(1'b0, 1'b1, 1'b0, 23'd1, 23'd0);
    strobe(1'b0, 1'b1, 1'b0, 23'd2, 23'd0);
    strobe(1'b0, 1'b1, 1'b0, 23'd3, 23'd0);
    chk("bp_pending", {30'd0, pending}, 32'd2);
    chk("bp_drop_cnt", {24'd0, drop_cnt}, 32'd1);
    chk("bp_overflow", {31'd0, overflow}, 32'd1);
    tick();
    count_mode = 1'b1;
    fifo_full = 1'b0;
    drain("bp");
    chk("bp_overflow_sticky", {31'd0, overflow}, 32'd1);
    clear_flags();
    chk("clr_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    chk("clr_overflow", {31'd0, overflow}, 32'd0);

    // simultaneous edges, one slot free, no pop: falling word drops
    tick();
    fifo_full = 1'b1;
    exp_q.push_back(24'h800010);
    strobe(1'b0, 1'b1, 1'b0, 23'h10, 23'h0);
    exp_q.push_back(24'h800020);
    strobe(1'b0, 1'b1, 1'b1, 23'h20, 23'h30);
    chk("sim1_pending", {30'd0, pending}, 32'd2);
    chk("sim1_drop_cnt", {24'd0, drop_cnt}, 32'd1);
    chk("sim1_overflow", {31'd0, overflow}, 32'd1);
    tick();
    fifo_full = 1'b0;
    drain("sim1");
    clear_flags();

    // simultaneous edges with a pop in the same cycle: nothing drops
    tick();
    fifo_full = 1'b1;
    exp_q.push_back(24'h800040);
    strobe(1'b0, 1'b1, 1'b0, 23'h40, 23'h0);
    exp_q.push_back(24'h800050);
    exp_q.push_back(24'h000060);
    tick();
    fifo_full = 1'b0;
    count_mode = 1'b0;
    rising_edge = 1'b1;
    falling_edge = 1'b1;
    count_p = 23'h50;
    count_m = 23'h60;
    tick();
    rising_edge = 1'b0;
    falling_edge = 1'b0;
    chk("sim2_pending", {30'd0, pending}, 32'd2);
    chk("sim2_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    chk("sim2_overflow", {31'd0, overflow}, 32'd0);
    drain("sim2");

    // drop counter saturation and clear-vs-drop priority
    tick();
    fifo_full = 1'b1;
    exp_q.push_back(24'h800001);
    exp_q.push_back(24'h800002);
    strobe(1'b0, 1'b1, 1'b0, 23'd1, 23'd0);
    strobe(1'b0, 1'b1, 1'b0, 23'd2, 23'd0);
    strobe(1'b0, 1'b1, 1'b1, $urandom_range(0, 8388607), $urandom_range(0, 8388607));
    chk("both_drop_cnt", {24'd0, drop_cnt}, 32'd2);
    for (int i = 0; i < 126; i++) begin
      strobe(1'b0, 1'b1, 1'b1, $urandom_range(0, 8388607), $urandom_range(0, 8388607));
    end
    chk("sat_254", {24'd0, drop_cnt}, 32'd254);
    strobe(1'b0, 1'b1, 1'b0, 23'd9, 23'd0);
    chk("sat_255", {24'd0, drop_cnt}, 32'd255);
    strobe(1'b0, 1'b0, 1'b1, 23'd0, 23'd9);
    chk("sat_hold", {24'd0, drop_cnt}, 32'd255);
    strobe(1'b0, 1'b1, 1'b1, 23'd9, 23'd9);
    chk("sat_hold2", {24'd0, drop_cnt}, 32'd255);
    tick();
    clr_overflow = 1'b1;
    rising_edge = 1'b1;
    count_p = 23'd5;
    tick();
    clr_overflow = 1'b0;
    rising_edge = 1'b0;
    chk("clr_drop_drop_cnt", {24'd0, drop_cnt}, 32'd1);
    chk("clr_drop_overflow", {31'd0, overflow}, 32'd1);
    clear_flags();
    chk("clr2_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    chk("clr2_overflow", {31'd0, overflow}, 32'd0);
    tick();
    fifo_full = 1'b0;
    drain("sat");

    // asynchronous reset during a write cycle
    tick();
    fifo_full = 1'b1;
    exp_q.push_back(24'h800070);
    exp_q.push_back(24'h800071);
    strobe(1'b0, 1'b1, 1'b0, 23'h70, 23'h0);
    strobe(1'b0, 1'b1, 1'b0, 23'h71, 23'h0);
    tick();
    fifo_full = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_12mhz);
      #2;
      if (fifo_wr_en) break;
    end
    chk("rst_wait_wr", {31'd0, fifo_wr_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    chk("arst_pending", {30'd0, pending}, 32'd0);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    exp_q.push_back(24'h000123);
    strobe(1'b0, 1'b0, 1'b1, 23'h0, 23'h123);
    drain("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global time bound
  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_word_packer.md
Name: count_word_packer

Overview:
Upstream stage of the measurement FIFO. It captures the 23-bit counter results (count_p / count_m) on counter edge strobes and forms 24-bit measurement words according to count_mode. Words are held in a small holding queue and written into the 24-bit FIFO with single-cycle write pulses that respect fifo_full. Words lost to backpressure are counted and flagged.

Parameters:
CNT_W, 23, counter result width; word width is CNT_W+1
QDEPTH, 2, holding queue depth (power of 2, >=2)
DROP_W, 8, dropped-word counter width

Ports:
clk_12mhz  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
count_mode  in  1  0 = ADC mode (both phases); 1 = AVK differential mode
rising_edge  in  1  one-clk strobe: count_p is final
falling_edge  in  1  one-clk strobe: count_m is final
count_p  in  CNT_W  positive-phase count
count_m  in  CNT_W  negative-phase count
fifo_full  in  1  FIFO full flag
fifo_wr_en  out  1  FIFO write strobe, registered
count  out  CNT_W+1  FIFO write data, registered
pending  out  log2(QDEPTH)+1  queue occupancy
drop_cnt  out  DROP_W  dropped words, saturating
overflow  out  1  sticky drop flag
clr_overflow  in  1  one-clk clear of overflow and drop_cnt

Behaviour:
- One clock, clk_12mhz. rst_n is asynchronous and active-low. All state updates on the posedge.
- Reset values: fifo_wr_en=0, count=0, pending=0, drop_cnt=0, overflow=0, queue empty, FSM=IDLE. Assertion of rst_n mid-write forces fifo_wr_en low immediately and discards queued words.
- Word forming, with count_mode sampled in the same cycle as the strobe:
  - mode 0, rising_edge: {1'b1, count_p}.
  - mode 0, falling_edge: {1'b0, count_m}.
  - mode 1, falling_edge: {1'b0,count_p} - {1'b0,count_m}, 24-bit two's complement with wrap and no saturation. rising_edge is ignored in mode 1.
- Simultaneous rising_edge and falling_edge in mode 0: both words enqueue, rising word first.
  - If only one slot is free, the rising word enqueues and the falling word drops.
  - If no slot is free, both drop and drop_cnt increments by 2, saturating.
- Enqueue with a full queue: the new word is discarded, drop_cnt increments (saturating at all-ones), and overflow is set.
  - A pop in the same cycle frees a slot first, so the push succeeds and nothing drops.
- clr_overflow clears overflow and drop_cnt. A drop in the same cycle wins: overflow=1, drop_cnt=number dropped that cycle.
- Queued words are never altered by later count_mode changes.
- Write FSM:
  - IDLE: if pending>0 and fifo_full=0, load count<=head, set fifo_wr_en<=1, pop, go to GAP.
  - GAP: fifo_wr_en<=0 and stay one cycle so the FIFO flags can update, then return to IDLE.
  - fifo_wr_en is never high on two consecutive cycles, giving a maximum throughput of 1 word per 2 clocks.
  - count holds the last written word between writes.
- Latency: a strobe sampled at edge k with an empty queue enqueues at edge k. If fifo_full was low at edge k+1, fifo_wr_en is high during cycle k+1..k+2.
- fifo_full is high: words stay queued indefinitely with no timeout; writing resumes the first IDLE cycle after fifo_full goes low.
- pending reflects the registered occupancy after the edge's push and pop.

Test Plan:
- Mode 0, empty queue: rising_edge with count_p=23'h012345 -> one fifo_wr_en pulse 2 clks later, count=24'h812345; then falling_edge with count_m=23'h000010 -> count=24'h000010.
- Mode 1: count_p=100, count_m=40, falling_edge -> count=24'd60. Then count_p=40, count_m=100 -> count=24'hFFFFC4. rising_edge alone -> no write.
- fifo_full held high, then 3 strobes -> pending=2, drop_cnt=1, overflow=1, no writes. Release fifo_full -> two pulses separated by one low cycle, in capture order.
- Simultaneous rising and falling edge with queue holding 1 word and fifo_full=1 -> rising word kept, drop_cnt +1. Same event with a pop in that cycle -> no drop.
- drop_cnt=255 plus a further drop -> stays 255. clr_overflow in the same cycle as a drop -> drop_cnt=1, overflow=1.
- rst_n asserted during a fifo_wr_en-high cycle -> fifo_wr_en=0 asynchronously, pending=0. After release, a new strobe writes normally.
